// File: rtl/loader_pkg.sv
// loader_pkg: shared definitions for the byte-stream program loader.
//   - command byte encodings of the framed boot stream
//   - FSM state encoding of the loader
//   - default memory depth in words
package loader_pkg;

  localparam logic [7:0] CMD_LOAD_I = 8'hA5;  // load instruction memory
  localparam logic [7:0] CMD_LOAD_D = 8'h5A;  // load data memory
  localparam logic [7:0] CMD_RUN    = 8'h0F;  // release the CPU
  localparam logic [7:0] CMD_HALT   = 8'hF0;  // hold the CPU in reset again

  localparam int unsigned MAX_WORDS_DEFAULT = 1024;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CNT_HI = 3'd1,
    CNT_LO = 3'd2,
    DATA   = 3'd3,
    WRITE  = 3'd4,
    RUN    = 3'd5
  } loader_state_t;

endpackage

// File: rtl/word_packer.sv
// word_packer: assembles four stream bytes into a big-endian 32-bit word.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   shift      - accept byte_in into the low byte of the word this cycle
//   clear      - restart the byte index at 0 (start of a new payload)
//   byte_in    - stream byte
//   word       - assembled word, MSB byte first in the stream
//   word_done  - the byte being shifted this cycle completes the word
module word_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        shift,
  input  logic        clear,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_done
);

  logic [1:0] byte_idx;

  // Last byte of a word is the one shifted while the index sits at 3.
  assign word_done = shift & (byte_idx == 2'd3);

  // Shift register and byte index; index wraps naturally after byte 3.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word     <= 32'd0;
      byte_idx <= 2'd0;
    end else if (clear) begin
      byte_idx <= 2'd0;
    end else if (shift) begin
      word     <= {word[23:0], byte_in};
      byte_idx <= byte_idx + 2'd1;
    end else begin
      byte_idx <= byte_idx;
    end
  end

endmodule

// File: rtl/program_loader.sv
// program_loader: byte-stream boot loader for the single-cycle CPU.
// Decodes framed commands (LOAD_I / LOAD_D with a 16-bit word count and
// big-endian payload, RUN, HALT), writes the assembled words from address 0
// through the CPU's external memory-load port and keeps the CPU in reset
// until a RUN command arrives.
// Ports:
//   clk, rst                     - clock, asynchronous active-high reset
//   byte_in, byte_valid          - incoming stream byte and its qualifier
//   byte_ready                   - loader can accept a byte this cycle
//   address, inst_data           - word address and write data (both memories)
//   write_instruction/write_data - one-cycle write strobes
//   cpu_rst                      - CPU reset, low only while running
//   busy                         - in the middle of a frame
//   error                        - sticky protocol-error flag
module program_loader
  import loader_pkg::*;
#(
  parameter int unsigned MAX_WORDS = MAX_WORDS_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic [9:0]  address,
  output logic [31:0] inst_data,
  output logic        write_instruction,
  output logic        write_data,
  output logic        cpu_rst,
  output logic        busy,
  output logic        error
);

  localparam logic [15:0] MAX_CNT = 16'(MAX_WORDS);

  loader_state_t state;
  loader_state_t state_next;

  logic        xfer;
  logic        target_is_i;
  logic [7:0]  cnt_hi;
  logic [15:0] count_word;
  logic [15:0] remaining;
  logic        err_set;
  logic        err_clr;
  logic        load_start;
  logic        pack_shift;
  logic        word_done;

  assign xfer       = byte_valid & byte_ready;
  assign count_word = {cnt_hi, byte_in};
  assign pack_shift = (state == DATA) & xfer;

  word_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .shift     (pack_shift),
    .clear     (load_start),
    .byte_in   (byte_in),
    .word      (inst_data),
    .word_done (word_done)
  );

  // Next-state decode, error set/clear and payload-start detection.
  always_comb begin
    state_next = state;
    err_set    = 1'b0;
    err_clr    = 1'b0;
    load_start = 1'b0;
    case (state)
      IDLE: begin
        if (xfer) begin
          case (byte_in)
            CMD_LOAD_I, CMD_LOAD_D: begin
              state_next = CNT_HI;
              err_clr    = 1'b1;
            end
            CMD_RUN: begin
              state_next = RUN;
              err_clr    = 1'b1;
            end
            CMD_HALT: begin
              state_next = IDLE;
              err_clr    = 1'b1;
            end
            default: begin
              state_next = IDLE;
              err_set    = 1'b1;
            end
          endcase
        end else begin
          state_next = IDLE;
        end
      end
      CNT_HI: begin
        if (xfer) begin
          state_next = CNT_LO;
        end else begin
          state_next = CNT_HI;
        end
      end
      CNT_LO: begin
        if (xfer) begin
          if (count_word == 16'd0) begin
            state_next = IDLE;
          end else if (count_word > MAX_CNT) begin
            state_next = IDLE;
            err_set    = 1'b1;
          end else begin
            state_next = DATA;
            load_start = 1'b1;
          end
        end else begin
          state_next = CNT_LO;
        end
      end
      DATA: begin
        if (word_done) begin
          state_next = WRITE;
        end else begin
          state_next = DATA;
        end
      end
      WRITE: begin
        if (remaining == 16'd1) begin
          state_next = IDLE;
        end else begin
          state_next = DATA;
        end
      end
      RUN: begin
        // Everything except HALT is swallowed while the CPU runs.
        if (xfer && (byte_in == CMD_HALT)) begin
          state_next = IDLE;
        end else begin
          state_next = RUN;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State plus registered outputs derived from the next state, so strobes,
  // byte_ready, cpu_rst and busy line up with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      byte_ready        <= 1'b0;
      write_instruction <= 1'b0;
      write_data        <= 1'b0;
      cpu_rst           <= 1'b1;
      busy              <= 1'b0;
      error             <= 1'b0;
    end else begin
      state             <= state_next;
      byte_ready        <= (state_next != WRITE);
      write_instruction <= (state_next == WRITE) & target_is_i;
      write_data        <= (state_next == WRITE) & ~target_is_i;
      cpu_rst           <= (state_next != RUN);
      busy              <= (state_next != IDLE) & (state_next != RUN);
      if (err_set) begin
        error <= 1'b1;
      end else if (err_clr) begin
        error <= 1'b0;
      end else begin
        error <= error;
      end
    end
  end

  // Frame bookkeeping: target memory, count capture, address and word count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target_is_i <= 1'b1;
      cnt_hi      <= 8'd0;
      remaining   <= 16'd0;
      address     <= 10'd0;
    end else begin
      if ((state == IDLE) && xfer &&
          ((byte_in == CMD_LOAD_I) || (byte_in == CMD_LOAD_D))) begin
        target_is_i <= (byte_in == CMD_LOAD_I);
      end else begin
        target_is_i <= target_is_i;
      end
      if ((state == CNT_HI) && xfer) begin
        cnt_hi <= byte_in;
      end else begin
        cnt_hi <= cnt_hi;
      end
      if (load_start) begin
        remaining <= count_word;
        address   <= 10'd0;
      end else if (state == WRITE) begin
        remaining <= remaining - 16'd1;
        address   <= address + 10'd1;
      end else begin
        remaining <= remaining;
        address   <= address;
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

  logic        clk;
  logic        rst;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [9:0]  address;
  logic [31:0] inst_data;
  logic        write_instruction;
  logic        write_data;
  logic        cpu_rst;
  logic        busy;
  logic        error;

  int checks = 0;
  int passes = 0;
  int ready_viol = 0;
  int dual_strobe = 0;

  logic [9:0]  log_addr[$];
  logic [31:0] log_data[$];
  logic        log_is_d[$];

  program_loader dut (
    .clk               (clk),
    .rst               (rst),
    .byte_in           (byte_in),
    .byte_valid        (byte_valid),
    .byte_ready        (byte_ready),
    .address           (address),
    .inst_data         (inst_data),
    .write_instruction (write_instruction),
    .write_data        (write_data),
    .cpu_rst           (cpu_rst),
    .busy              (busy),
    .error             (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every memory write as the memory would see it.
  always @(negedge clk) begin
    if (!rst && (write_instruction || write_data)) begin
      log_addr.push_back(address);
      log_data.push_back(inst_data);
      log_is_d.push_back(write_data);
      if (byte_ready) ready_viol++;
      if (write_instruction && write_data) dual_strobe++;
    end
  end

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
    log_is_d.delete();
    ready_viol = 0;
    dual_strobe = 0;
  endtask

  // Called at a negedge; returns at the negedge after the byte was accepted.
  task automatic send(input logic [7:0] b);
    int n;
    byte_in = b;
    byte_valid = 1'b1;
    n = 0;
    while (byte_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      $display("FAIL send_timeout: byte %h never accepted, byte_ready=%b required 1", b, byte_ready);
    end
    @(negedge clk);
  endtask

  task automatic send_gap(input logic [7:0] b);
    int k;
    k = $urandom_range(0, 3);
    byte_valid = 1'b0;
    byte_in = 8'h00;
    repeat (k) @(negedge clk);
    send(b);
  endtask

  task automatic idle(input int n);
    byte_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if ({byte_ready, address, inst_data, write_instruction, write_data, cpu_rst, busy, error}
        !== {1'b0, 10'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      $display("FAIL %s: rdy=%b addr=%0d data=%h wi=%b wd=%b cpu_rst=%b busy=%b err=%b required 0 0 0 0 0 1 0 0",
               tag, byte_ready, address, inst_data, write_instruction, write_data, cpu_rst, busy, error);
    end else passes++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    byte_valid = 1'b0;
    byte_in = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_values");
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (byte_ready !== 1'b1) $display("FAIL ready_after_reset: got %b required 1", byte_ready);
    else passes++;
  endtask

  task automatic test_load_i();
    logic [7:0] bytes [11];
    bytes = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    clear_log();
    foreach (bytes[i]) send(bytes[i]);
    idle(4);
    checks++;
    if (log_addr.size() != 2) $display("FAIL load_i_count: got %0d writes required 2", log_addr.size());
    else passes++;
    if (log_addr.size() == 2) begin
      checks++;
      if ({log_addr[0], log_data[0], log_is_d[0]} !== {10'd0, 32'h12345678, 1'b0})
        $display("FAIL load_i_word0: got a=%0d d=%h isd=%b required a=0 d=12345678 isd=0",
                 log_addr[0], log_data[0], log_is_d[0]);
      else passes++;
      checks++;
      if ({log_addr[1], log_data[1], log_is_d[1]} !== {10'd1, 32'h9ABCDEF0, 1'b0})
        $display("FAIL load_i_word1: got a=%0d d=%h isd=%b required a=1 d=9abcdef0 isd=0",
                 log_addr[1], log_data[1], log_is_d[1]);
      else passes++;
    end
    checks++;
    if ({cpu_rst, busy, error, ready_viol, dual_strobe} !== {1'b1, 1'b0, 1'b0, 32'd0, 32'd0})
      $display("FAIL load_i_end: cpu_rst=%b busy=%b err=%b rdy_viol=%0d dual=%0d required 1 0 0 0 0",
               cpu_rst, busy, error, ready_viol, dual_strobe);
    else passes++;
  endtask

  task automatic test_load_d_run();
    logic [7:0] bytes [7];
    bytes = '{8'h5A, 8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    clear_log();
    foreach (bytes[i]) send(bytes[i]);
    idle(3);
    checks++;
    if (log_addr.size() != 1 || {log_addr[0], log_data[0], log_is_d[0]} !== {10'd0, 32'hDEADBEEF, 1'b1})
      $display("FAIL load_d_word: got %0d writes first a=%0d d=%h isd=%b required 1 write a=0 d=deadbeef isd=1",
               log_addr.size(), log_addr.size() ? log_addr[0] : 10'd0,
               log_data.size() ? log_data[0] : 32'd0, log_is_d.size() ? log_is_d[0] : 1'b0);
    else passes++;
    checks++;
    if (cpu_rst !== 1'b1) $display("FAIL pre_run_cpu_rst: got %b required 1", cpu_rst);
    else passes++;
    send(8'h0F);
    checks++;
    if ({cpu_rst, busy} !== 2'b00) $display("FAIL run_cpu_rst: cpu_rst=%b busy=%b required 0 0", cpu_rst, busy);
    else passes++;
    // LOAD frame while running is discarded
    clear_log();
    send(8'hA5); send(8'h00); send(8'h01);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    idle(3);
    checks++;
    if (log_addr.size() != 0 || cpu_rst !== 1'b0)
      $display("FAIL run_ignores_load: writes=%0d cpu_rst=%b required 0 0", log_addr.size(), cpu_rst);
    else passes++;
    send(8'hF0);
    checks++;
    if ({cpu_rst, busy} !== 2'b10) $display("FAIL halt_cpu_rst: cpu_rst=%b busy=%b required 1 0", cpu_rst, busy);
    else passes++;
    idle(1);
  endtask

  task automatic test_bad_cmd();
    clear_log();
    send(8'h33);
    idle(1);
    checks++;
    if ({error, busy} !== 2'b10) $display("FAIL bad_cmd_error: err=%b busy=%b required 1 0", error, busy);
    else passes++;
    send(8'hA5);
    checks++;
    if ({error, busy} !== 2'b01) $display("FAIL error_clear: err=%b busy=%b required 0 1", error, busy);
    else passes++;
    send(8'h00); send(8'h00);
    idle(2);
    checks++;
    if ({error, busy} !== 2'b00 || log_addr.size() != 0)
      $display("FAIL zero_count: err=%b busy=%b writes=%0d required 0 0 0", error, busy, log_addr.size());
    else passes++;
  endtask

  task automatic test_count_overflow();
    clear_log();
    send(8'hA5); send(8'h04); send(8'h01);
    idle(2);
    checks++;
    if ({error, busy, cpu_rst} !== 3'b101 || log_addr.size() != 0)
      $display("FAIL count_1025: err=%b busy=%b cpu_rst=%b writes=%0d required 1 0 1 0",
               error, busy, cpu_rst, log_addr.size());
    else passes++;
    send(8'hF0);
    checks++;
    if (error !== 1'b0) $display("FAIL halt_clears_error: got %b required 0", error);
    else passes++;
    idle(1);
  endtask

  task automatic test_gaps();
    logic [7:0]  bytes [15];
    logic [31:0] exp [3];
    bytes = '{8'hA5, 8'h00, 8'h03, 8'h01, 8'h02, 8'h03, 8'h04,
              8'hA0, 8'hB1, 8'hC2, 8'hD3, 8'hFF, 8'h00, 8'h80, 8'h7F};
    exp = '{32'h01020304, 32'hA0B1C2D3, 32'hFF00807F};
    clear_log();
    foreach (bytes[i]) send_gap(bytes[i]);
    idle(4);
    checks++;
    if (log_addr.size() != 3) $display("FAIL gaps_count: got %0d writes required 3", log_addr.size());
    else passes++;
    for (int i = 0; i < 3; i++) begin
      if (i < log_addr.size()) begin
        checks++;
        if ({log_addr[i], log_data[i], log_is_d[i]} !== {10'(i), exp[i], 1'b0})
          $display("FAIL gaps_word%0d: got a=%0d d=%h isd=%b required a=%0d d=%h isd=0",
                   i, log_addr[i], log_data[i], log_is_d[i], i, exp[i]);
        else passes++;
      end
    end
    checks++;
    if (ready_viol != 0 || dual_strobe != 0)
      $display("FAIL write_ready_low: rdy_in_write=%0d dual=%0d required 0 0", ready_viol, dual_strobe);
    else passes++;
  endtask

  task automatic test_reset_mid();
    clear_log();
    send(8'hA5); send(8'h00); send(8'h02);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    send(8'hAA); send(8'hBB);
    checks++;
    if ({address, inst_data} !== {10'd1, 32'h3344AABB})
      $display("FAIL mid_frame_state: addr=%0d data=%h required 1 3344aabb", address, inst_data);
    else passes++;
    byte_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_reset_mid");
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (log_addr.size() != 1) $display("FAIL partial_word_written: got %0d writes required 1", log_addr.size());
    else passes++;
    rst = 1'b0;
    @(negedge clk);
    clear_log();
    send(8'hA5); send(8'h00); send(8'h01);
    send(8'hCA); send(8'hFE); send(8'hBA); send(8'hBE);
    idle(3);
    checks++;
    if (log_addr.size() != 1 || {log_addr[0], log_data[0], log_is_d[0]} !== {10'd0, 32'hCAFEBABE, 1'b0})
      $display("FAIL after_reset_frame: writes=%0d a=%0d d=%h required 1 write a=0 d=cafebabe",
               log_addr.size(), log_addr.size() ? log_addr[0] : 10'd0,
               log_data.size() ? log_data[0] : 32'd0);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_load_i();
    test_load_d_run();
    test_bad_cmd();
    test_count_overflow();
    test_gaps();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
